cmd_dispatcher: RTL and testbench

Parametrised UART command dispatcher that replaces the hand-written command state machine at the top level.
- Decodes one received command byte against a compile-time table of N client codes.
- Raises a one-hot activate to the matching client, holds it until that client's done, then waits for the UART to go quiet.
- Muxes the selected client's TX request onto the single UART transmitter.
- New behaviour: per-command timeout, NAK reply for unknown commands, error pulses.

---
 rtl/cmd_dispatcher_pkg.sv | 40 ++++
 rtl/cmd_dispatcher_lookup.sv | 27 ++
 rtl/cmd_dispatcher.sv | 142 ++++++++++++++
 tb/tb_cmd_dispatcher.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_dispatcher_pkg.sv
// Shared types and helpers for the UART command dispatcher.
package cmd_dispatcher_pkg;

  // Largest table the lookup helper handles: 16 clients, codes up to 32 bits.
  localparam int MAX_CLIENTS = 16;
  localparam int CMD_MAX_W   = 32;
  localparam int TBL_MAX_W   = MAX_CLIENTS * CMD_MAX_W;

  // ASCII NAK, sent back when a received byte matches no client code.
  localparam logic [7:0] DEF_NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_NAK_SEND,
    ST_NAK_WAIT,
    ST_RELEASE
  } disp_state_t;

  // Priority match of code against the first n entries (w bits each) of tbl.
  // Returns {hit, idx[3:0]}; the lowest matching index wins.
  function automatic logic [4:0] cmd_index(input logic [TBL_MAX_W-1:0] tbl,
                                           input logic [CMD_MAX_W-1:0] code,
                                           input int n,
                                           input int w);
    logic [CMD_MAX_W-1:0] mask;
    logic [CMD_MAX_W-1:0] entry;
    logic [4:0]           res;
    mask = (CMD_MAX_W'(1) << w) - CMD_MAX_W'(1);
    res  = '0;
    for (int i = 0; i < MAX_CLIENTS; i++) begin
      entry = tbl[i*w +: CMD_MAX_W] & mask;
      if (i < n && !res[4] && entry == (code & mask)) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cmd_dispatcher_lookup.sv
// Combinational priority match of the received byte against the client code table.
module cmd_dispatcher_lookup
  import cmd_dispatcher_pkg::*;
#(
  parameter int                        N_CLIENTS = 8,
  parameter int                        CMD_W     = 8,
  parameter logic [N_CLIENTS*CMD_W-1:0] CMD_TABLE = '0,
  parameter int                        IDX_W     = 3
) (
  input  logic [CMD_W-1:0] code,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  localparam logic [TBL_MAX_W-1:0] TBL_EXT = TBL_MAX_W'(CMD_TABLE);

  logic [4:0] res;

  // Table is a constant, so this reduces to N parallel comparators plus a priority pick.
  always_comb begin
    res = cmd_index(TBL_EXT, CMD_MAX_W'(code), N_CLIENTS, CMD_W);
  end

  assign hit = res[4];
  assign idx = IDX_W'(res[3:0]);

endmodule

// File: rtl/cmd_dispatcher.sv
// UART command dispatcher: decodes a command byte, enables one client until it
// finishes (or times out), muxes that client onto the UART TX, NAKs unknown bytes.
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int                         N_CLIENTS   = 8,
  parameter int                         CMD_W       = 8,
  // Entry 0 is the rightmost byte.
  parameter logic [N_CLIENTS*CMD_W-1:0] CMD_TABLE   = {8'h72, 8'h71, 8'h31, 8'h25,
                                                       8'h24, 8'h23, 8'h22, 8'h21},
  parameter int                         TIMEOUT_CYC = 0,
  parameter int                         NAK_EN      = 1,
  parameter logic [CMD_W-1:0]           NAK_BYTE    = CMD_W'(DEF_NAK_BYTE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CMD_W-1:0]             rx_data,
  input  logic                         rx_ready,
  input  logic                         tx_active,
  input  logic [N_CLIENTS-1:0]         client_done,
  input  logic [N_CLIENTS*CMD_W-1:0]   client_tx_data,
  input  logic [N_CLIENTS-1:0]         client_tx_start,
  output logic [N_CLIENTS-1:0]         activate,
  output logic [CMD_W-1:0]             tx_data,
  output logic                         tx_start,
  output logic [CMD_W-1:0]             cur_cmd,
  output logic                         busy,
  output logic                         err_unknown,
  output logic                         err_timeout
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic [N_CLIENTS-1:0] ACT_ONE  = N_CLIENTS'(1);

  disp_state_t      state;
  logic [IDX_W-1:0] sel;
  logic [CNT_W-1:0] cnt;
  logic [CMD_W-1:0] tx_data_q;
  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
  logic             tmo_hit;

  cmd_dispatcher_lookup #(
    .N_CLIENTS (N_CLIENTS),
    .CMD_W     (CMD_W),
    .CMD_TABLE (CMD_TABLE),
    .IDX_W     (IDX_W)
  ) u_lookup (
    .code (rx_data),
    .hit  (lk_hit),
    .idx  (lk_idx)
  );

  assign busy    = (state != ST_IDLE);
  assign tmo_hit = (TIMEOUT_CYC > 0) && (cnt == CNT_LAST);

  // TX mux: selected client while active, one-shot NAK, otherwise hold last byte.
  always_comb begin
    tx_data  = tx_data_q;
    tx_start = 1'b0;
    if (state == ST_ACTIVE) begin
      tx_data  = client_tx_data[sel*CMD_W +: CMD_W];
      tx_start = client_tx_start[sel];
    end else if (state == ST_NAK_SEND && !tx_active) begin
      tx_data  = NAK_BYTE;
      tx_start = 1'b1;
    end
  end

  // Dispatcher FSM with registered activate, cur_cmd, error pulses and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= '0;
      activate    <= '0;
      cur_cmd     <= '0;
      err_unknown <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
      tx_data_q   <= '0;
    end else begin
      err_unknown <= 1'b0;
      err_timeout <= 1'b0;
      tx_data_q   <= tx_data;
      if ((state == ST_ACTIVE || state == ST_NAK_WAIT) && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (rx_ready) begin
            if (lk_hit) begin
              state    <= ST_ACTIVE;
              sel      <= lk_idx;
              activate <= ACT_ONE << lk_idx;
              cur_cmd  <= rx_data;
              cnt      <= '0;
            end else begin
              err_unknown <= 1'b1;
              state       <= (NAK_EN != 0) ? ST_NAK_SEND : ST_RELEASE;
            end
          end
        end
        ST_ACTIVE: begin
          // done takes priority over an expiring timeout on the same cycle
          if (client_done[sel]) begin
            activate <= '0;
            cur_cmd  <= '0;
            state    <= ST_RELEASE;
          end else if (tmo_hit) begin
            activate    <= '0;
            cur_cmd     <= '0;
            err_timeout <= 1'b1;
            state       <= ST_RELEASE;
          end
        end
        ST_NAK_SEND: begin
          if (!tx_active) begin
            state <= ST_NAK_WAIT;
            cnt   <= '0;
          end
        end
        ST_NAK_WAIT: begin
          if (tx_active || tmo_hit) begin
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // wait for the trigger byte to clear so it is not decoded twice
          cur_cmd <= '0;
          if (!rx_ready && !tx_active) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher with a 16-cycle client timeout.
module tb_cmd_dispatcher;

  localparam int N = 8;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   rx_data = '0;
  logic           rx_ready = 1'b0;
  logic           tx_active = 1'b0;
  logic [N-1:0]   client_done = '0;
  logic [N*W-1:0] client_tx_data = '0;
  logic [N-1:0]   client_tx_start = '0;
  logic [N-1:0]   activate;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic [W-1:0]   cur_cmd;
  logic           busy;
  logic           err_unknown;
  logic           err_timeout;

  int n_chk = 0;
  int n_bad = 0;
  int hi;

  cmd_dispatcher #(
    .N_CLIENTS   (N),
    .CMD_W       (W),
    .CMD_TABLE   ({8'h72, 8'h71, 8'h31, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21}),
    .TIMEOUT_CYC (16),
    .NAK_EN      (1),
    .NAK_BYTE    (8'h15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .tx_active       (tx_active),
    .client_done     (client_done),
    .client_tx_data  (client_tx_data),
    .client_tx_start (client_tx_start),
    .activate        (activate),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .cur_cmd         (cur_cmd),
    .busy            (busy),
    .err_unknown     (err_unknown),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_activate", 32'(activate), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cur_cmd", 32'(cur_cmd), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_err", 32'({err_unknown, err_timeout}), 32'h0);

    // known command 0x23 -> client 2
    rx_data = 8'h23; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("k_activate", 32'(activate), 32'h04);
    chk("k_cur_cmd", 32'(cur_cmd), 32'h23);
    chk("k_busy", 32'(busy), 32'h1);
    client_done = 8'h20;
    tick();
    chk("k_other_done", 32'(activate), 32'h04);
    client_done = 8'h04;
    tick();
    client_done = '0;
    chk("k_done_act", 32'(activate), 32'h0);
    chk("k_rel_busy", 32'(busy), 32'h1);
    chk("k_rel_cmd", 32'(cur_cmd), 32'h0);
    tick();
    chk("k_idle_busy", 32'(busy), 32'h0);

    // TX mux on client 6 (0x71)
    rx_data = 8'h71; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("m_activate", 32'(activate), 32'h40);
    client_tx_data[6*W +: W] = 8'hA5;
    client_tx_start[6] = 1'b1;
    #1;
    chk("m_tx_data", 32'(tx_data), 32'hA5);
    chk("m_tx_start", 32'(tx_start), 32'h1);
    client_tx_start[6] = 1'b0;
    client_tx_data[3*W +: W] = 8'h5A;
    client_tx_start[3] = 1'b1;
    #1;
    chk("m_other_start", 32'(tx_start), 32'h0);
    chk("m_other_data", 32'(tx_data), 32'hA5);
    client_done[6] = 1'b1;
    tick();
    client_done = '0;
    chk("m_rel_start", 32'(tx_start), 32'h0);
    chk("m_rel_hold", 32'(tx_data), 32'hA5);
    client_tx_start = '0;
    tick();
    chk("m_idle_busy", 32'(busy), 32'h0);

    // unknown command 0x99 -> NAK
    rx_data = 8'h99; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    #1;
    chk("u_err", 32'(err_unknown), 32'h1);
    chk("u_nak_start", 32'(tx_start), 32'h1);
    chk("u_nak_data", 32'(tx_data), 32'h15);
    chk("u_activate", 32'(activate), 32'h0);
    tick();
    chk("u_err_gone", 32'(err_unknown), 32'h0);
    chk("u_start_once", 32'(tx_start), 32'h0);
    chk("u_data_hold", 32'(tx_data), 32'h15);
    tx_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("u_wait_busy", 32'(busy), 32'h1);
      chk("u_wait_act", 32'(activate | N'(tx_start)), 32'h0);
    end
    tx_active = 1'b0;
    tick();
    chk("u_idle_busy", 32'(busy), 32'h0);

    // timeout on client 0 (0x21)
    rx_data = 8'h21; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    hi = activate[0] ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!activate[0]) break;
      hi++;
    end
    chk("t_active_cycles", 32'(hi), 32'd16);
    chk("t_err", 32'(err_timeout), 32'h1);
    chk("t_busy_rel", 32'(busy), 32'h1);
    tick();
    chk("t_err_gone", 32'(err_timeout), 32'h0);
    chk("t_idle_busy", 32'(busy), 32'h0);

    // done on the 16th active cycle beats the timeout
    rx_data = 8'h21; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("r_still_act", 32'(activate), 32'h01);
    client_done[0] = 1'b1;
    tick();
    client_done = '0;
    chk("r_act_off", 32'(activate), 32'h0);
    chk("r_no_err", 32'(err_timeout), 32'h0);
    tick();
    chk("r_idle_busy", 32'(busy), 32'h0);

    // reset while active
    rx_data = 8'h24; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("x_activate", 32'(activate), 32'h08);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("x_rst_act", 32'(activate), 32'h0);
    chk("x_rst_busy", 32'(busy), 32'h0);
    chk("x_rst_cmd", 32'(cur_cmd), 32'h0);

    // rx_ready held after done: no second activation
    rx_data = 8'h25; rx_ready = 1'b1;
    tick();
    chk("d_activate", 32'(activate), 32'h10);
    client_done[4] = 1'b1;
    tick();
    client_done = '0;
    chk("d_done_act", 32'(activate), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("d_hold_act", 32'(activate), 32'h0);
      chk("d_hold_busy", 32'(busy), 32'h1);
    end
    rx_ready = 1'b0;
    tick();
    chk("d_idle_busy", 32'(busy), 32'h0);
    chk("d_idle_act", 32'(activate), 32'h0);
    rx_data = 8'h31; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("d_new_act", 32'(activate), 32'h20);
    chk("d_new_cmd", 32'(cur_cmd), 32'h31);
    client_done[5] = 1'b1;
    tick();
    client_done = '0;
    tick();
    chk("d_end_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
